hr_peak_rate: RTL and testbench

Converts the MAX30100 IR sample stream into a heart rate in beats per minute. It detects pulse peaks with hysteresis and counts samples between successive peaks. An iterative restoring divider then computes BPM = 60·SAMPLE_RATE_HZ / interval. It sits between the FIFO-read/filter stage of the sensor subsystem and the `heart_rate` input of the LCD display stage, and runs on the 1 MHz system clock.

---
 rtl/hr_peak_rate.sv | 273 +++++++++++++++++++++++++++
 tb/tb_hr_peak_rate.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hr_peak_rate.sv
// hr_peak_rate: hysteresis peak detector on the IR sample stream plus a serial
// divider that turns the beat interval into BPM. Build option HR_AVG4_EN averages the last four BPM values.
module hr_peak_rate #(
  parameter int unsigned SAMPLE_RATE_HZ = 32'd100,
  parameter int unsigned HYST           = 32'd64,
  parameter int unsigned MIN_INTERVAL   = 32'd30,
  parameter int unsigned MAX_INTERVAL   = 32'd300
) (
  input  logic        clk_1MHz,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [15:0] ir_sample,
  output logic [15:0] heart_rate,
  output logic        hr_valid,
  output logic        beat
);

  localparam logic [15:0] NUMER   = 16'(32'd60 * SAMPLE_RATE_HZ);
  localparam logic [16:0] HYST_W  = 17'(HYST);
  localparam logic [15:0] MIN_INT = 16'(MIN_INTERVAL);
  localparam logic [15:0] MAX_INT = 16'(MAX_INTERVAL);
  localparam logic [15:0] SAT_INT = 16'(MAX_INTERVAL + 32'd1);

  typedef enum logic {DET_RISE = 1'b0, DET_FALL = 1'b1} det_state_t;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2,
    DIV_AVG  = 2'd3
  } div_state_t;

  det_state_t  det_state_r, det_next_s;
  logic [15:0] run_max_r, run_max_next_s;
  logic [15:0] run_min_r, run_min_next_s;
  logic [16:0] samp_hyst_s, min_hyst_s;
  logic        peak_s;
  logic [15:0] interval_r, interval_next_s;
  logic        have_prev_r, have_prev_next_s;
  logic        timeout_s;
  logic        start_div_s;
  logic        div_busy_s;
  div_state_t  div_state_r, div_next_s;
  logic [15:0] rem_r, rem_next_s;
  logic [16:0] rem_sh_s, diff_s;
  logic [15:0] quo_r, quo_next_s;
  logic [15:0] dvs_r, dvs_next_s;
  logic [3:0]  cnt_r, cnt_next_s;
  logic        q_bit_s;
  logic [15:0] hr_next_s;
  logic        hr_valid_next_s;

  assign div_busy_s = (div_state_r != DIV_IDLE);

  // Peak/trough tracking with hysteresis; sums are 17 bits so nothing wraps
  always_comb begin
    det_next_s     = det_state_r;
    run_max_next_s = run_max_r;
    run_min_next_s = run_min_r;
    peak_s         = 1'b0;
    samp_hyst_s    = {1'b0, ir_sample} + HYST_W;
    min_hyst_s     = {1'b0, run_min_r} + HYST_W;
    if (sample_valid) begin
      case (det_state_r)
        DET_RISE: begin
          if (ir_sample > run_max_r) begin
            run_max_next_s = ir_sample;
          end else begin
            run_max_next_s = run_max_r;
          end
          if (samp_hyst_s < {1'b0, run_max_r}) begin
            peak_s         = 1'b1;
            det_next_s     = DET_FALL;
            run_min_next_s = ir_sample;
          end else begin
            det_next_s     = DET_RISE;
          end
        end
        DET_FALL: begin
          if (ir_sample < run_min_r) begin
            run_min_next_s = ir_sample;
          end else begin
            run_min_next_s = run_min_r;
          end
          if ({1'b0, ir_sample} > min_hyst_s) begin
            det_next_s     = DET_RISE;
            run_max_next_s = ir_sample;
          end else begin
            det_next_s     = DET_FALL;
          end
        end
        default: det_next_s = DET_RISE;
      endcase
    end else begin
      det_next_s = det_state_r;
    end
  end

  // Beat interval counter, timeout detection and divider start decision
  always_comb begin
    interval_next_s  = interval_r;
    have_prev_next_s = have_prev_r;
    timeout_s        = 1'b0;
    start_div_s      = 1'b0;
    if (peak_s) begin
      interval_next_s = 16'd1;
      if (!have_prev_r) begin
        have_prev_next_s = 1'b1;
      end else if ((interval_r >= MIN_INT) && (interval_r <= MAX_INT) && !div_busy_s) begin
        start_div_s = 1'b1;
      end else begin
        start_div_s = 1'b0;
      end
    end else if (sample_valid && (interval_r < SAT_INT)) begin
      interval_next_s = interval_r + 16'd1;
      if (interval_r == MAX_INT) begin
        timeout_s        = 1'b1;
        have_prev_next_s = 1'b0;
      end else begin
        timeout_s        = 1'b0;
      end
    end else begin
      interval_next_s = interval_r;
    end
  end

  // Detector and interval state registers
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      det_state_r <= DET_RISE;
      run_max_r   <= 16'h0000;
      run_min_r   <= 16'hFFFF;
      interval_r  <= 16'h0000;
      have_prev_r <= 1'b0;
    end else begin
      det_state_r <= det_next_s;
      run_max_r   <= run_max_next_s;
      run_min_r   <= run_min_next_s;
      interval_r  <= interval_next_s;
      have_prev_r <= have_prev_next_s;
    end
  end

  // Restoring divider: numerator shifts out of quo_r MSB-first as quotient bits shift in
  always_comb begin
    div_next_s = div_state_r;
    rem_next_s = rem_r;
    quo_next_s = quo_r;
    dvs_next_s = dvs_r;
    cnt_next_s = cnt_r;
    rem_sh_s   = {rem_r, quo_r[15]};
    diff_s     = rem_sh_s - {1'b0, dvs_r};
    q_bit_s    = ~diff_s[16];
    case (div_state_r)
      DIV_IDLE: begin
        if (start_div_s) begin
          div_next_s = DIV_RUN;
          rem_next_s = 16'h0000;
          quo_next_s = NUMER;
          dvs_next_s = interval_r;
          cnt_next_s = 4'd0;
        end else begin
          div_next_s = DIV_IDLE;
        end
      end
      DIV_RUN: begin
        if (q_bit_s) begin
          rem_next_s = diff_s[15:0];
        end else begin
          rem_next_s = rem_sh_s[15:0];
        end
        quo_next_s = {quo_r[14:0], q_bit_s};
        cnt_next_s = cnt_r + 4'd1;
        if (cnt_r == 4'd15) begin
          div_next_s = DIV_DONE;
        end else begin
          div_next_s = DIV_RUN;
        end
      end
      DIV_DONE: begin
`ifdef HR_AVG4_EN
        if (timeout_s) begin
          div_next_s = DIV_IDLE;
        end else begin
          div_next_s = DIV_AVG;
        end
`else
        div_next_s = DIV_IDLE;
`endif
      end
      DIV_AVG: div_next_s = DIV_IDLE;
      default: div_next_s = DIV_IDLE;
    endcase
  end

  // Divider state and datapath registers
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      div_state_r <= DIV_IDLE;
      rem_r       <= 16'h0000;
      quo_r       <= 16'h0000;
      dvs_r       <= 16'h0000;
      cnt_r       <= 4'd0;
    end else begin
      div_state_r <= div_next_s;
      rem_r       <= rem_next_s;
      quo_r       <= quo_next_s;
      dvs_r       <= dvs_next_s;
      cnt_r       <= cnt_next_s;
    end
  end

`ifdef HR_AVG4_EN
  logic [3:0][15:0] win_r;
  logic             win_fill_r;
  logic [17:0]      avg_sum_s;

  assign avg_sum_s = {2'b00, win_r[0]} + {2'b00, win_r[1]} + {2'b00, win_r[2]} + {2'b00, win_r[3]};

  // Four-entry BPM window; the first value after reset or timeout fills every slot
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      win_r      <= {4{16'h0000}};
      win_fill_r <= 1'b0;
    end else if (timeout_s) begin
      win_r      <= {4{16'h0000}};
      win_fill_r <= 1'b0;
    end else if (div_state_r == DIV_DONE) begin
      if (win_fill_r) begin
        win_r <= {win_r[2], win_r[1], win_r[0], quo_r};
      end else begin
        win_r <= {4{quo_r}};
      end
      win_fill_r <= 1'b1;
    end
  end
`endif

  // Output update; a timeout overrides a result landing in the same cycle
  always_comb begin
    hr_next_s       = heart_rate;
    hr_valid_next_s = 1'b0;
    if (timeout_s) begin
      hr_next_s       = 16'h0000;
      hr_valid_next_s = 1'b1;
`ifdef HR_AVG4_EN
    end else if (div_state_r == DIV_AVG) begin
      hr_next_s       = avg_sum_s[17:2];
      hr_valid_next_s = 1'b1;
`else
    end else if (div_state_r == DIV_DONE) begin
      hr_next_s       = quo_r;
      hr_valid_next_s = 1'b1;
`endif
    end else begin
      hr_next_s       = heart_rate;
      hr_valid_next_s = 1'b0;
    end
  end

  // Registered outputs
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      heart_rate <= 16'h0000;
      hr_valid   <= 1'b0;
      beat       <= 1'b0;
    end else begin
      heart_rate <= hr_next_s;
      hr_valid   <= hr_valid_next_s;
      beat       <= peak_s;
    end
  end

endmodule

// File: tb/tb_hr_peak_rate.sv
// Testbench for hr_peak_rate: directed triangle/flat waveforms, a behavioural
// reference model feeds beat and heart-rate scoreboards checked by a monitor.
`timescale 1ns/1ps
module tb_hr_peak_rate;

  localparam int HYST  = 64;
  localparam int MIN_I = 30;
  localparam int MAX_I = 300;
  localparam int NUMER = 6000;
  localparam int GAP   = 20;
`ifdef HR_AVG4_EN
  localparam int LAT = 18;
  localparam bit AVG = 1'b1;
`else
  localparam int LAT = 17;
  localparam bit AVG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] ir_sample = 16'd0;
  logic [15:0] heart_rate;
  logic        hr_valid;
  logic        beat;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;

  typedef struct {
    longint at;
    int     val;
  } hr_ev_t;

  hr_ev_t hr_q[$];
  longint beat_q[$];

  // reference model state
  bit m_fall;
  int m_max;
  int m_min;
  int m_int;
  bit m_prev;
  int m_win[4];
  bit m_full;

  hr_peak_rate dut (
    .clk_1MHz     (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .ir_sample    (ir_sample),
    .heart_rate   (heart_rate),
    .hr_valid     (hr_valid),
    .beat         (beat)
  );

  always #500 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fall = 1'b0;
    m_max  = 0;
    m_min  = 65535;
    m_int  = 0;
    m_prev = 1'b0;
    m_full = 1'b0;
    for (int i = 0; i < 4; i++) m_win[i] = 0;
  endtask

  task automatic push_rate(input int q, input longint at);
    hr_ev_t ev;
    int sum;
    if (AVG) begin
      if (!m_full) begin
        for (int i = 0; i < 4; i++) m_win[i] = q;
      end else begin
        m_win[3] = m_win[2];
        m_win[2] = m_win[1];
        m_win[1] = m_win[0];
        m_win[0] = q;
      end
      m_full = 1'b1;
      sum = m_win[0] + m_win[1] + m_win[2] + m_win[3];
      ev.val = sum / 4;
    end else begin
      ev.val = q;
    end
    ev.at = at;
    hr_q.push_back(ev);
  endtask

  task automatic model_step(input int v, input longint ncyc);
    bit pk;
    hr_ev_t ev;
    pk = 1'b0;
    if (!m_fall) begin
      if (v > m_max) m_max = v;
      if (v + HYST < m_max) begin
        pk = 1'b1;
        m_fall = 1'b1;
        m_min = v;
      end
    end else begin
      if (v < m_min) m_min = v;
      if (v > m_min + HYST) begin
        m_fall = 1'b0;
        m_max = v;
      end
    end
    if (pk) begin
      beat_q.push_back(ncyc);
      if (!m_prev) m_prev = 1'b1;
      else if (m_int >= MIN_I && m_int <= MAX_I) push_rate(NUMER / m_int, ncyc + LAT);
      m_int = 1;
    end else if (m_int <= MAX_I) begin
      m_int++;
      if (m_int == MAX_I + 1) begin
        ev.at  = ncyc;
        ev.val = 0;
        hr_q.push_back(ev);
        m_prev = 1'b0;
        m_full = 1'b0;
      end
    end
  endtask

  task automatic send(input int v);
    repeat (GAP - 1) @(posedge clk);
    #1;
    sample_valid = 1'b1;
    ir_sample    = 16'(v);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    model_step(v, cyc);
  endtask

  function automatic int tri_val(input int period, input int p, input int base, input int amp);
    int h;
    h = period / 2;
    if (p <= h) return base + (amp * p) / h;
    return base + (amp * (period - p)) / (period - h);
  endfunction

  task automatic tri_run(input int period, input int first, input int count, input int base, input int amp);
    for (int i = 0; i < count; i++) send(tri_val(period, (first + i) % period, base, amp));
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    sample_valid = 1'b0;
    hr_q.delete();
    beat_q.delete();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (LAT + 5) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor, sampled on the falling edge
  hr_ev_t mon_ev;
  longint mon_b;
  always @(negedge clk) begin
    if (rst_n) begin
      if (beat) begin
        if (beat_q.size() > 0) mon_b = beat_q.pop_front();
        else mon_b = -1;
        chk("beat_cycle", cyc, mon_b);
      end else if (beat_q.size() > 0 && beat_q[0] <= cyc) begin
        void'(beat_q.pop_front());
        chk("beat_missing", beat, 1);
      end
      if (hr_valid) begin
        if (hr_q.size() > 0) begin
          mon_ev = hr_q.pop_front();
          chk("hr_cycle", cyc, mon_ev.at);
          chk("heart_rate", heart_rate, mon_ev.val);
        end else begin
          chk("hr_valid_unexpected", hr_valid, 0);
        end
      end else if (hr_q.size() > 0 && hr_q[0].at <= cyc) begin
        void'(hr_q.pop_front());
        chk("hr_valid_missing", hr_valid, 1);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_heart_rate", heart_rate, 0);
    chk("rst_hr_valid", hr_valid, 0);
    chk("rst_beat", beat, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 75-sample period: 80 BPM from the second beat on
    tri_run(75, 0, 300, 0, 2000);
    drain();
    chk("hr_80bpm", heart_rate, 80);

    // flat input forces a single timeout to 0
    for (int i = 0; i < 300; i++) send(1000);
    drain();
    chk("hr_timeout", heart_rate, 0);
    for (int i = 0; i < 20; i++) send(1000);
    drain();

    // 25-sample period is faster than the shortest accepted interval
    do_reset();
    tri_run(25, 0, 150, 0, 2000);
    drain();
    chk("hr_too_fast", heart_rate, 0);

    // swing below hysteresis: no beats at all
    do_reset();
    tri_run(20, 0, 100, 1000, 50);
    drain();
    chk("hr_small_amp", heart_rate, 0);

    // reset 5 cycles into a division aborts it
    do_reset();
    tri_run(60, 0, 92, 0, 2000);
    repeat (5) @(posedge clk);
    do_reset();
    chk("abort_heart_rate", heart_rate, 0);
    chk("abort_hr_valid", hr_valid, 0);
    repeat (30) @(posedge clk);
    #1;
    tri_run(60, 0, 92, 0, 2000);
    drain();
    chk("hr_after_abort", heart_rate, 100);

    // period 60 then 75; trough padded so the changeover interval is 75
    do_reset();
    tri_run(60, 0, 92, 0, 2000);
    drain();
    chk("hr_p60", heart_rate, 100);
    tri_run(60, 92, 28, 0, 2000);
    for (int i = 0; i < 7; i++) send(0);
    tri_run(75, 0, 40, 0, 2000);
    drain();
    chk("hr_p75", heart_rate, AVG ? 95 : 80);

    chk("pending_events", hr_q.size() + beat_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
